// File: rtl/crc_multi.sv
// crc_multi: a bank of NCH independent, bus-programmable CRC engines.
// Each channel has its own register block (DATA, GPOLY, CTRL, STATUS).
// Each channel shifts one 32-bit message word through a CRC of width W,
// which is configurable from 8 to 32 bits.
// A one-word holding register lets software queue the next word.
// When the engine finishes, it takes the queued word on the same edge,
// so no idle cycle is inserted between words.
module crc_multi #(
    parameter int          NCH  = 2,
    parameter int          BPC  = 1,
    parameter logic [31:0] BASE = 32'h4003_2000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            Sel,
    input  logic            RW,
    input  logic [31:0]     addr,
    input  logic [31:0]     data_wr,
    output logic [31:0]     data_rd,
    output logic [NCH-1:0]  done
);

    // Cycles per word, and the counter value seen on the completion edge.
    localparam int         NCYC = 32 / BPC;
    localparam logic [4:0] LAST = 5'(NCYC - 1);

    // Transpose a 32-bit word.
    // Mode encoding: 00 none, 01 bit-reverse each byte,
    // 10 full reverse, 11 byte swap.
    function automatic logic [31:0] f_transpose(input logic [31:0] x, input logic [1:0] mode);
        logic [31:0] y;
        y = x;
        case (mode)
            2'b01:   for (int i = 0; i < 32; i++) y[(i & ~7) | (7 - (i & 7))] = x[i];
            2'b10:   for (int i = 0; i < 32; i++) y[31 - i] = x[i];
            2'b11:   y = {x[7:0], x[15:8], x[23:16], x[31:24]};
            default: y = x;
        endcase
        return y;
    endfunction

    // Mask with the low W bits set.
    // W is 32 when TCRC is set, 16 when WLEN is 0, and max(WLEN+1, 8) otherwise.
    function automatic logic [31:0] f_mask(input logic [31:0] ctrl);
        logic [5:0] w;
        if (ctrl[24])
            return 32'hFFFF_FFFF;
        if (ctrl[4:0] == 5'd0)
            return 32'h0000_FFFF;
        w = {1'b0, ctrl[4:0]} + 6'd1;
        if (w < 6'd8)
            return 32'h0000_00FF;
        // When w is 32 the shift yields 0, and 0 - 1 gives all ones.
        return (32'h1 << w) - 32'h1;
    endfunction

    // Decode the bus address into channel and register selects.
    logic [31:0] w_off;
    logic        w_hit;
    logic [2:0]  w_ch;
    logic [1:0]  w_reg;
    logic        w_wr;
    logic [31:0] w_ch_rd [NCH];

    assign w_off = addr - BASE;
    assign w_hit = (w_off < 32'(16 * NCH)) && (w_off[1:0] == 2'b00);
    assign w_ch  = w_off[6:4];
    assign w_reg = w_off[3:2];
    assign w_wr  = Sel && RW && w_hit;

    for (genvar c = 0; c < NCH; c++) begin : g_ch
        logic [31:0] r_ctrl, r_gpoly, r_crc, r_chk, r_sr, r_hold;
        logic [31:0] r_snap_mask, r_snap_poly;
        logic        r_busy, r_pend, r_ovf, r_done;
        logic [4:0]  r_cnt;

        logic        w_sel, w_wr_data, w_wr_gpoly, w_wr_ctrl, w_wr_status;
        logic        w_last, w_fb;
        logic [31:0] w_mask, w_word, w_top, w_chk_nx, w_sr_nx, w_rd_val;

        assign w_sel       = w_wr && (w_ch == 3'(c));
        assign w_wr_data   = w_sel && (w_reg == 2'd0);
        assign w_wr_gpoly  = w_sel && (w_reg == 2'd1);
        assign w_wr_ctrl   = w_sel && (w_reg == 2'd2);
        assign w_wr_status = w_sel && (w_reg == 2'd3);

        assign w_mask = f_mask(r_ctrl);
        assign w_word = f_transpose(data_wr, r_ctrl[31:30]);
        assign w_top  = r_snap_mask ^ (r_snap_mask >> 1);
        assign w_last = (r_cnt == LAST);

        // Advance the checksum by BPC message bits, using the snapshotted width and polynomial.
        always_comb begin
            // NOTE: blocking assignments here chain BPC bit-steps within one cycle; every output gets a default first so no latch is inferred.
            w_chk_nx = r_chk;
            w_sr_nx  = r_sr;
            w_fb     = 1'b0;
            for (int b = 0; b < BPC; b++) begin
                w_fb     = |(w_chk_nx & w_top);
                w_chk_nx = {w_chk_nx[30:0], w_sr_nx[31]} & r_snap_mask;
                if (w_fb)
                    w_chk_nx = w_chk_nx ^ r_snap_poly;
                w_sr_nx  = {w_sr_nx[30:0], 1'b0};
            end
        end

        // Read value of this channel's register selected by the address.
        always_comb begin
            w_rd_val = '0;
            case (w_reg)
                2'd0: w_rd_val = f_transpose((r_ctrl[26] ? (r_crc ^ w_mask) : r_crc) & w_mask,
                                             r_ctrl[29:28]);
                2'd1: w_rd_val = r_gpoly;
                2'd2: w_rd_val = r_ctrl;
                default: w_rd_val = {29'd0, r_pend, r_ovf, r_busy};
            endcase
        end

        // Register writes, engine sequencing, holding register and status flags.
        always_ff @(posedge clk) begin
            if (rst) begin
                r_ctrl      <= '0;
                r_gpoly     <= 32'h0000_1021;
                r_crc       <= 32'hFFFF_FFFF;
                r_chk       <= 32'hFFFF_FFFF;
                r_sr        <= '0;
                r_hold      <= '0;
                r_snap_mask <= '0;
                r_snap_poly <= '0;
                r_busy      <= 1'b0;
                r_pend      <= 1'b0;
                r_ovf       <= 1'b0;
                r_done      <= 1'b0;
                r_cnt       <= '0;
            end else begin
                r_done <= 1'b0;
                if (w_wr_ctrl)
                    r_ctrl <= data_wr;
                if (w_wr_gpoly)
                    r_gpoly <= data_wr;
                if (w_wr_status && data_wr[1])
                    r_ovf <= 1'b0;

                if (r_busy) begin
                    r_chk <= w_chk_nx;
                    r_sr  <= w_sr_nx;
                    if (w_last) begin
                        r_crc  <= w_chk_nx;
                        r_done <= 1'b1;
                        r_cnt  <= '0;
                        if (r_pend) begin
                            // Queued word starts on the completion edge, using current settings.
                            r_sr        <= r_hold;
                            r_pend      <= 1'b0;
                            r_snap_mask <= w_mask;
                            r_snap_poly <= r_gpoly & w_mask;
                        end else if (w_wr_data && !r_ctrl[25]) begin
                            // A word written on the completion edge is taken directly.
                            r_sr        <= w_word;
                            r_snap_mask <= w_mask;
                            r_snap_poly <= r_gpoly & w_mask;
                        end else begin
                            r_busy <= 1'b0;
                        end
                    end else begin
                        r_cnt <= r_cnt + 5'd1;
                    end
                end

                if (w_wr_data) begin
                    if (r_ctrl[25]) begin
                        // Seed write: abort any work in flight and suppress its done pulse.
                        r_crc  <= w_word & w_mask;
                        r_chk  <= w_word & w_mask;
                        r_busy <= 1'b0;
                        r_pend <= 1'b0;
                        r_cnt  <= '0;
                        r_done <= 1'b0;
                    end else if (!r_busy) begin
                        r_sr        <= w_word;
                        r_busy      <= 1'b1;
                        r_cnt       <= '0;
                        r_snap_mask <= w_mask;
                        r_snap_poly <= r_gpoly & w_mask;
                    end else if (!r_pend) begin
                        if (!w_last) begin
                            r_hold <= w_word;
                            r_pend <= 1'b1;
                        end
                    end else begin
                        r_ovf <= 1'b1;
                    end
                end
            end
        end

        assign done[c]    = r_done;
        assign w_ch_rd[c] = w_rd_val;
    end

    // Combinational read mux; unmapped or misaligned addresses return zero.
    always_comb begin
        data_rd = '0;
        for (int c = 0; c < NCH; c++)
            if (w_hit && (w_ch == 3'(c)))
                data_rd = w_ch_rd[c];
    end

endmodule

// File: tb/tb_crc_multi.sv
// tb_crc_multi: directed self-checking bench for crc_multi (NCH=2, BPC=1).
`timescale 1ns/1ps
module tb_crc_multi;

    localparam logic [31:0] CH0 = 32'h4003_2000;
    localparam logic [31:0] CH1 = 32'h4003_2010;
    localparam logic [31:0] R_DATA = 32'h0, R_GPOLY = 32'h4, R_CTRL = 32'h8, R_STAT = 32'hC;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        Sel = 1'b0;
    logic        RW = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] data_wr = '0;
    logic [31:0] data_rd;
    logic [1:0]  done;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] rd, exp_v, chk_m, word, wa, wb;
    int          pulses;

    crc_multi #(.NCH(2), .BPC(1), .BASE(32'h4003_2000)) dut (
        .clk(clk), .rst(rst), .Sel(Sel), .RW(RW), .addr(addr),
        .data_wr(data_wr), .data_rd(data_rd), .done(done)
    );

    always #50 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        Sel = 1'b1; RW = 1'b1; addr = a; data_wr = d;
        @(posedge clk);
        #1;
        Sel = 1'b0; RW = 1'b0;
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        Sel = 1'b1; RW = 1'b0; addr = a;
        #1;
        d = data_rd;
        Sel = 1'b0;
    endtask

    task automatic read_check(input string tag, input logic [31:0] a, input logic [31:0] exp);
        logic [31:0] v;
        bus_read(a, v);
        check(tag, v, exp);
    endtask

    // Step n cycles; done must stay low until the n-th cycle, then equal exp.
    task automatic wait_done(input logic [1:0] exp, input int n, input string tag);
        int early;
        early = 0;
        for (int i = 1; i <= n; i++) begin
            @(posedge clk);
            #1;
            if (i < n && done !== 2'b00) early++;
        end
        check({tag, "_early"}, 32'(early), 32'd0);
        check({tag, "_done"}, {30'd0, done}, {30'd0, exp});
    endtask

    // Reference CRC: shift 32 message bits MSB-first into a W-bit checksum.
    function automatic logic [31:0] crc_ref(input logic [31:0] c, input logic [31:0] d,
                                            input logic [31:0] p, input int w);
        logic [31:0] msk;
        logic        top;
        msk = (w == 32) ? 32'hFFFF_FFFF : ((32'h1 << w) - 32'h1);
        for (int i = 31; i >= 0; i--) begin
            top = c[w-1];
            c = ((c << 1) | {31'd0, d[i]}) & msk;
            if (top) c = c ^ (p & msk);
        end
        return c;
    endfunction

    function automatic logic [31:0] rev8(input logic [31:0] v);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < 8; i++) r[7-i] = v[i];
        return r;
    endfunction

    initial begin
        // Reset and reset-state register values.
        step(3);
        rst = 1'b0;
        check("reset_done", {30'd0, done}, 32'd0);
        read_check("rst_ch0_data", CH0 + R_DATA, 32'h0000_FFFF);
        read_check("rst_ch0_gpoly", CH0 + R_GPOLY, 32'h0000_1021);
        read_check("rst_ch0_ctrl", CH0 + R_CTRL, 32'h0);
        read_check("rst_ch0_stat", CH0 + R_STAT, 32'h0);
        read_check("rst_ch1_data", CH1 + R_DATA, 32'h0000_FFFF);
        read_check("rst_ch1_gpoly", CH1 + R_GPOLY, 32'h0000_1021);
        read_check("rst_ch1_ctrl", CH1 + R_CTRL, 32'h0);
        read_check("rst_ch1_stat", CH1 + R_STAT, 32'h0);
        read_check("unmapped_hi", CH0 + 32'h20, 32'h0);
        read_check("unmapped_lo", CH0 - 32'h4, 32'h0);
        read_check("misaligned", CH0 + 32'h1, 32'h0);

        // Seed 0, one word of 1: done after 32 cycles, result 1.
        bus_write(CH0 + R_CTRL, 32'h0200_0000);
        bus_write(CH0 + R_DATA, 32'h0);
        bus_write(CH0 + R_CTRL, 32'h0);
        read_check("seed0_data", CH0 + R_DATA, 32'h0);
        bus_write(CH0 + R_DATA, 32'h0000_0001);
        read_check("busy_stat", CH0 + R_STAT, 32'h1);
        wait_done(2'b01, 32, "w1");
        step(1);
        check("w1_pulse_one_cycle", {30'd0, done}, 32'd0);
        read_check("w1_data", CH0 + R_DATA, 32'h0000_0001);
        read_check("w1_idle", CH0 + R_STAT, 32'h0);

        // GPOLY changed mid-word: the in-flight word keeps the snapshot (0x00010000 -> 0x1021).
        bus_write(CH0 + R_CTRL, 32'h0200_0000);
        bus_write(CH0 + R_DATA, 32'h0);
        bus_write(CH0 + R_CTRL, 32'h0);
        bus_write(CH0 + R_DATA, 32'h0001_0000);
        bus_write(CH0 + R_GPOLY, 32'h0000_8005);
        wait_done(2'b01, 31, "snap");
        read_check("snap_data", CH0 + R_DATA, 32'h0000_1021);
        read_check("snap_gpoly", CH0 + R_GPOLY, 32'h0000_8005);

        // ch1: back-to-back words with pending, then an overflowed third write.
        wa = 32'h0001_0000;
        wb = 32'h1234_5678;
        bus_write(CH1 + R_CTRL, 32'h0200_0000);
        bus_write(CH1 + R_DATA, 32'h0);
        bus_write(CH1 + R_CTRL, 32'h0);
        bus_write(CH1 + R_DATA, wa);
        bus_write(CH1 + R_DATA, wb);
        read_check("pend_stat", CH1 + R_STAT, 32'h5);
        bus_write(CH1 + R_DATA, 32'hDEAD_BEEF);
        read_check("ovf_stat", CH1 + R_STAT, 32'h7);
        wait_done(2'b10, 30, "b2b_first");
        read_check("b2b_first_data", CH1 + R_DATA, 32'h0000_1021);
        read_check("b2b_mid_stat", CH1 + R_STAT, 32'h3);
        wait_done(2'b10, 32, "b2b_second");
        exp_v = crc_ref(crc_ref(32'h0, wa, 32'h1021, 16), wb, 32'h1021, 16);
        read_check("b2b_second_data", CH1 + R_DATA, exp_v);
        read_check("b2b_end_stat", CH1 + R_STAT, 32'h2);
        bus_write(CH1 + R_STAT, 32'h2);
        read_check("ovf_clear", CH1 + R_STAT, 32'h0);

        // ch0: CRC-8 (WLEN=7, poly 0x07), FXOR, per-byte bit-reversed reads.
        bus_write(CH0 + R_CTRL, 32'h1600_0007);
        bus_write(CH0 + R_GPOLY, 32'h0000_0007);
        bus_write(CH0 + R_DATA, 32'h0000_00FF);
        bus_write(CH0 + R_CTRL, 32'h1400_0007);
        chk_m = 32'hFF;
        read_check("crc8_seed", CH0 + R_DATA, rev8((chk_m ^ 32'hFF) & 32'hFF));
        for (int k = 0; k < 3; k++) begin
            word = $urandom;
            bus_write(CH0 + R_DATA, word);
            wait_done(2'b01, 32, "crc8");
            chk_m = crc_ref(chk_m, word, 32'h07, 8);
            read_check("crc8_data", CH0 + R_DATA, rev8((chk_m ^ 32'hFF) & 32'hFF));
        end

        // ch1: 32-bit width, byte-swap on write, various read transposes.
        bus_write(CH1 + R_CTRL, 32'hC300_0000);
        bus_write(CH1 + R_DATA, 32'h1122_3344);
        bus_write(CH1 + R_CTRL, 32'h0100_0000);
        read_check("tot_swap", CH1 + R_DATA, 32'h4433_2211);
        bus_write(CH1 + R_CTRL, 32'h2100_0000);
        read_check("totr_full", CH1 + R_DATA, 32'h8844_CC22);
        bus_write(CH1 + R_CTRL, 32'h1100_0000);
        read_check("totr_byte", CH1 + R_DATA, 32'h22CC_4488);

        // Reset mid-word on ch0, with a same-cycle CTRL write that must lose.
        bus_write(CH0 + R_DATA, 32'hA5A5_5A5A);
        step(10);
        rst = 1'b1;
        Sel = 1'b1; RW = 1'b1; addr = CH0 + R_CTRL; data_wr = 32'hFFFF_FFFF;
        step(1);
        rst = 1'b0;
        Sel = 1'b0; RW = 1'b0;
        check("rst_mid_done", {30'd0, done}, 32'd0);
        read_check("rst2_ch0_data", CH0 + R_DATA, 32'h0000_FFFF);
        read_check("rst2_ch0_gpoly", CH0 + R_GPOLY, 32'h0000_1021);
        read_check("rst2_ch0_ctrl", CH0 + R_CTRL, 32'h0);
        read_check("rst2_ch0_stat", CH0 + R_STAT, 32'h0);
        read_check("rst2_ch1_data", CH1 + R_DATA, 32'h0000_FFFF);
        read_check("rst2_ch1_ctrl", CH1 + R_CTRL, 32'h0);
        read_check("rst2_ch1_stat", CH1 + R_STAT, 32'h0);
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            step(1);
            if (done !== 2'b00) pulses++;
        end
        check("rst_no_done", 32'(pulses), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/crc_multi.md
CRC_MULTI -- requirements
Module: crc_multi

Interface
REQ-001 Parameter NCH, default 2: number of independent CRC channels (1..8).
REQ-002 Parameter BPC, default 1: message bits consumed per clock per channel (1, 2, 4, 8, 16 or 32).
REQ-003 Parameter BASE, default 32'h4003_2000: byte address of channel 0 register block.
REQ-004 Ports, clock and reset first: clk in 1 clock; rst in 1 reset; Sel in 1 bus select; RW in 1 1=write 0=read; addr in 32 byte address; data_wr in 32 write data; data_rd out 32 read data; done out NCH per-channel completion pulse.
REQ-005 One clock, clk; reset rst is synchronous and active-high.

Function
REQ-006 Channel c occupies BASE+16c..BASE+16c+15: +0 DATA, +4 GPOLY, +8 CTRL, +C STATUS; other addresses read 0, writes ignored.
REQ-007 CTRL fields: TOT[31:30], TOTR[29:28], FXOR[26], WAS[25], TCRC[24], WLEN[4:0]; other bits stored, no effect.
REQ-008 Width W: TCRC=1 -> 32; TCRC=0 and WLEN=0 -> 16; else W=max(WLEN+1,8); MASK = low W bits set.
REQ-009 Write transpose by TOT: 00 none, 01 bit-reverse within each byte, 10 full 32-bit reverse, 11 byte swap only; read transpose by TOTR, same encoding.
REQ-010 Write accepted on a clk edge with Sel=1, RW=1; register reads are combinational, no latency.
REQ-011 DATA read: FXOR=1 -> (CRC_DATA ^ MASK) transposed per TOTR; FXOR=0 -> CRC_DATA transposed; bits above W read 0.
REQ-012 STATUS read: bit0 BUSY, bit1 OVF (sticky), bit2 PEND (holding register full), others 0.
REQ-013 DATA write with WAS=1: CRC_DATA and checksum <= transposed data_wr & MASK; engine aborted, PEND cleared, no done pulse.
REQ-014 DATA write with WAS=0, channel idle: transposed word loaded into shift register; GPOLY and W snapshotted; BUSY=1 from next cycle.
REQ-015 Per bit: m=chk[W-1]; chk={chk,msb of shift reg} & MASK; if m, chk ^= GPOLY & MASK; shift reg shifts left one.
REQ-016 Engine processes BPC bits per cycle; a word completes 32/BPC cycles after acceptance edge.
REQ-017 Completion edge: CRC_DATA <= chk; done[c] high exactly one cycle; BUSY drops unless PEND set.
REQ-018 DATA write (WAS=0) while BUSY and PEND=0: word stored, PEND=1; consumed the cycle after completion with no idle cycle; PEND cleared.
REQ-019 DATA write (WAS=0) while BUSY and PEND=1: word dropped, OVF=1; engine unaffected.
REQ-020 STATUS write: bit1=1 clears OVF (write-1-to-clear); other bits ignored.
REQ-021 CTRL/GPOLY writes during BUSY update the register immediately; in-flight word uses snapshot, next word uses new values.
REQ-022 Channels fully independent; simultaneous completions on several channels pulse all corresponding done bits together.

Reset
REQ-023 rst=1 at a clk edge: per channel CTRL=0, GPOLY=32'h0000_1021, CRC_DATA=checksum=32'hFFFF_FFFF, BUSY=PEND=OVF=0; done=0.
REQ-024 Reset mid-computation discards in-flight and pending words; no done pulse; reset dominates a same-cycle write.

Verification
REQ-025 Reset, read each channel -> DATA 32'h0000_FFFF (W=16), GPOLY 32'h0000_1021, CTRL 0, STATUS 0.
REQ-026 BPC=1, ch0 CTRL=32'h0200_0000, DATA=0, CTRL=0, DATA=32'h0000_0001 -> done[0] 32 cycles later, DATA reads 32'h0000_0001.
REQ-027 Seed ch1 to 0, two back-to-back DATA writes -> second starts without gap, done[1] pulses at 32/BPC and 64/BPC, PEND set then cleared.
REQ-028 Third DATA write while BUSY and PEND=1 -> OVF=1, result equals two-word model; STATUS write 32'h2 -> OVF=0.
REQ-029 TCRC=0, WLEN=7, GPOLY=32'h07, FXOR=1, TOTR=01 random words -> DATA matches bench model of REQ-008..REQ-015.
REQ-030 Assert rst mid-word on ch0 while ch1 idle -> no done pulse, all registers at REQ-023 values next cycle.
